// File: rtl/rtype_instr_encoder_if.sv
// Request and instruction-memory write channels of the R-type instruction encoder.
// Latency: none (signal bundle only).
// Backpressure: req_ready throttles the producer; imem_wready stalls the memory write.
//
// Ports (slave = encoder view):
//   req_valid/req_ready  request handshake
//   req_op/rd/rs1/rs2    ALU op and register indices
//   req_last             final request of a program
//   imem_we/imem_wready  memory write handshake
//   imem_waddr/wdata     byte address and encoded instruction
interface rtype_instr_encoder_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic        req_last;
    logic        imem_we;
    logic        imem_wready;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;

    // Producer of requests and consumer (memory) of the writes.
    modport master (
        output req_valid, req_op, req_rd, req_rs1, req_rs2, req_last, imem_wready,
        input  req_ready, imem_we, imem_waddr, imem_wdata
    );

    // The encoder itself.
    modport slave (
        input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_last, imem_wready,
        output req_ready, imem_we, imem_waddr, imem_wdata
    );
endinterface

// File: rtl/rtype_instr_encoder.sv
// Encodes ALU-op requests into RV32I R-type words and writes them to consecutive imem addresses.
// Latency: request accepted at edge k -> imem_we with its word from edge k+1; 1 word/cycle sustained.
// Backpressure: imem_wready=0 holds the write stable; FIFO fills and req_ready drops when full.
//
// Ports: clk, rst_n (async active-low), clear (sync flush), bus (rtype_instr_encoder_if.slave),
//        done (one-cycle end-of-program pulse), err (sticky illegal-op flag), instr_count (words written).
// Optional feature: define RTYPE_ENC_ILLEGAL_CHECK_EN to drop illegal ops and flag them on err;
// otherwise every op is encoded as-is and err is tied low.
module rtype_instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    rtype_instr_encoder_if.slave        bus,
    output logic                        done,
    output logic                        err,
    output logic [15:0]                 instr_count
);

    typedef struct packed {
        logic [3:0] op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } req_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic logic [31:0] encode(input req_t r);
        return {1'b0, r.op[3], 5'b0, r.rs2, r.rs1, r.op[2:0], r.rd, 7'b0110011};
    endfunction

    logic [1:0]  state;
    req_t        req_in;
    req_t        head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic        load;
    logic        head_legal;
    logic        out_vld;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [15:0] count_q;
    logic        wr_fire;
    logic        out_free;

    assign req_in = '{op: bus.req_op, rd: bus.req_rd, rs1: bus.req_rs1, rs2: bus.req_rs2};

    assign bus.req_ready  = ((state == ST_IDLE) || (state == ST_RUN)) && !fifo_full;
    assign push           = bus.req_valid && bus.req_ready && !clear;

    assign wr_fire        = out_vld && bus.imem_wready;
    // The output register can take a new word if it is empty or being written this cycle.
    assign out_free       = !out_vld || wr_fire;

`ifdef RTYPE_ENC_ILLEGAL_CHECK_EN
    assign head_legal = !head.op[3] || (head.op[2:0] == 3'b000) || (head.op[2:0] == 3'b101);
`else
    assign head_legal = 1'b1;
`endif

    // Illegal entries are popped without waiting for the output register, so they never
    // occupy a write slot or advance the address.
    assign pop  = !fifo_empty && (out_free || !head_legal);
    assign load = pop && head_legal;

    rtype_enc_fifo #(
        .W     ($bits(req_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (push),
        .din   (req_in),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Output register, address and write counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            data_q  <= 32'h0;
            addr_q  <= BASE_ADDR;
            count_q <= 16'h0;
        end else if (clear) begin
            out_vld <= 1'b0;
            data_q  <= 32'h0;
            addr_q  <= BASE_ADDR;
            count_q <= 16'h0;
        end else begin
            if (wr_fire) begin
                addr_q  <= addr_q + 32'd4;
                count_q <= count_q + 16'd1;
            end
            if (load) begin
                out_vld <= 1'b1;
                data_q  <= encode(head);
            end else if (wr_fire) begin
                out_vld <= 1'b0;
            end
        end
    end

    // Program sequencing. Once the last request is accepted no further requests enter,
    // so the program is finished when both the FIFO and the output register run dry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (clear) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (push) state <= bus.req_last ? ST_DRAIN : ST_RUN;
                end
                ST_RUN: begin
                    if (push && bus.req_last) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (fifo_empty && out_free) state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef RTYPE_ENC_ILLEGAL_CHECK_EN
    logic err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (clear) begin
            err_q <= 1'b0;
        end else if (pop && !head_legal) begin
            err_q <= 1'b1;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign bus.imem_we    = out_vld;
    assign bus.imem_waddr = addr_q;
    assign bus.imem_wdata = data_q;
    assign done           = (state == ST_DONE);
    assign instr_count    = count_q;

endmodule

// Generic synchronous FIFO with registered pointers and a fall-through-free read port.
// Latency: an entry pushed at edge k is visible on dout after edge k.
// Backpressure: push is ignored while full (even if a pop happens that cycle); pop ignored while empty.
module rtype_enc_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wptr] <= din;
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule
